// File: rtl/csr_trap_ctrl.sv
// -----------------------------------------------------------------------------
// csr_trap_ctrl
//
// Sequencing controller for the machine-mode CSR file. It takes one-shot
// requests from decode/execute (ecall trap entry, mret trap return and Zicsr
// read-modify-write) and walks a fixed multi-cycle sequence. In each write
// cycle it drives the matching CSR write enable and write data. When the
// sequence completes it returns the redirect PC and the CSR read result.
//
// Optional feature: define CSR_CTRL_IRQ_EN to let a level machine-timer
// interrupt (irq with mstatus.MIE=1) start a trap sequence from IDLE.
// Without the macro, irq is ignored and no interrupt path is built.
//
// Ports
//   clk, rst        core clock; synchronous active-high reset
//   start           request strobe, sampled only in IDLE
//   is_ecall        request is ecall (highest priority)
//   is_mret         request is mret
//   csr_op          00 none, 01 CSRRW, 10 CSRRS, 11 CSRRC
//   csr_addr        CSR address from the instruction
//   rs1_data        rs1 operand or zero-extended uimm
//   src_zero        rs1 index / uimm is zero; suppresses the RS/RC write
//   pc              PC of the requesting instruction
//   irq             level machine-timer interrupt (CSR_CTRL_IRQ_EN only)
//   mepc_val, mstatus_val, mtvec_val   current CSR values
//   csr_rst         CSR file read result for csr_num
//   csr_num         zero-extended csr_addr, latched at accept
//   *_data, *_wen   CSR write data and write enables
//   busy            high in every non-IDLE state
//   done            one-cycle completion pulse
//   redirect        with done: the core must load next_pc
//   next_pc         target PC, held until the next completion
//   rd_data         old CSR value for CSR ops, held until the next completion
// -----------------------------------------------------------------------------
module csr_trap_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_ecall,
  input  logic            is_mret,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            src_zero,
  input  logic [XLEN-1:0] pc,
  input  logic            irq,
  input  logic [XLEN-1:0] mepc_val,
  input  logic [XLEN-1:0] mstatus_val,
  input  logic [XLEN-1:0] mtvec_val,
  input  logic [XLEN-1:0] csr_rst,
  output logic [XLEN-1:0] csr_num,
  output logic [XLEN-1:0] mepc_data,
  output logic [XLEN-1:0] mstatus_data,
  output logic [XLEN-1:0] mcause_data,
  output logic [XLEN-1:0] mtvec_data,
  output logic            mepc_wen,
  output logic            mstatus_wen,
  output logic            mcause_wen,
  output logic            mtvec_wen,
  output logic            busy,
  output logic            done,
  output logic            redirect,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] rd_data
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    T_SAVE = 3'd1,
    T_STAT = 3'd2,
    R_STAT = 3'd3,
    C_WB   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  localparam logic [XLEN-1:0] ECALL_CAUSE = XLEN'(11);
  localparam logic [XLEN-1:0] IRQ_CAUSE   = {1'b1, {(XLEN-4){1'b0}}, 3'b111};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [11:0]       r_addr;
  logic [XLEN-1:0]   r_rs1;
  logic              r_src_zero;
  logic [1:0]        r_op;
  logic              r_irq;
  logic              r_redirect;
  logic [XLEN-1:0]   r_next_pc;
  logic [XLEN-1:0]   r_rd_data;

  logic              w_accept;
  logic              w_take_irq;
  logic              w_known;
  logic [XLEN-1:0]   w_old;
  logic [XLEN-1:0]   w_new;
  logic              w_csr_wr;
  logic [XLEN-1:0]   w_mstatus_trap;
  logic [XLEN-1:0]   w_mstatus_ret;

`ifdef CSR_CTRL_IRQ_EN
  // A pending enabled interrupt wins over any simultaneous start.
  assign w_take_irq = (r_state == IDLE) && irq && mstatus_val[3];
  logic w_unused_bits;
  assign w_unused_bits = ^mtvec_val[1:0];
`else
  assign w_take_irq = 1'b0;
  logic w_unused_bits;
  assign w_unused_bits = ^{irq, mtvec_val[1:0]};
`endif

  // A plain start needs at least one op kind, otherwise it is dropped.
  assign w_accept = (r_state == IDLE) && !w_take_irq && start &&
                    (is_ecall || is_mret || (csr_op != 2'b00));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_take_irq)            w_state_nxt = T_SAVE;
        else if (w_accept) begin
          if (is_ecall)            w_state_nxt = T_SAVE;
          else if (is_mret)        w_state_nxt = R_STAT;
          else                     w_state_nxt = C_WB;
        end
      end
      T_SAVE:  w_state_nxt = T_STAT;
      T_STAT:  w_state_nxt = DONE;
      R_STAT:  w_state_nxt = DONE;
      C_WB:    w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and request registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_irq      <= 1'b0;
      r_redirect <= 1'b0;
      r_next_pc  <= '0;
      r_rd_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept || w_take_irq) begin
        r_pc       <= pc;
        r_addr     <= csr_addr;
        r_rs1      <= rs1_data;
        r_src_zero <= src_zero;
        r_op       <= csr_op;
        r_irq      <= w_take_irq;
      end
      // Completion results are loaded on the last working cycle so they are
      // stable during DONE and hold afterwards.
      case (r_state)
        T_STAT: begin
          r_next_pc  <= {mtvec_val[XLEN-1:2], 2'b00};
          r_redirect <= 1'b1;
        end
        R_STAT: begin
          r_next_pc  <= mepc_val;
          r_redirect <= 1'b1;
        end
        C_WB: begin
          r_next_pc  <= r_pc + XLEN'(4);
          r_rd_data  <= w_old;
          r_redirect <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // CSR read-modify-write datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    w_known = 1'b0;
    case (r_addr)
      A_MSTATUS, A_MTVEC, A_MEPC, A_MCAUSE: w_known = 1'b1;
      default:                              w_known = 1'b0;
    endcase
  end

  // Unimplemented CSRs read as zero regardless of the read port.
  assign w_old = w_known ? csr_rst : '0;

  always_comb begin
    w_new = w_old;
    case (r_op)
      OP_RW:   w_new = r_rs1;
      OP_RS:   w_new = w_old | r_rs1;
      OP_RC:   w_new = w_old & ~r_rs1;
      default: w_new = w_old;
    endcase
  end

  assign w_csr_wr = (r_state == C_WB) && w_known &&
                    ((r_op == OP_RW) || !r_src_zero);

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
  always_comb begin
    w_mstatus_trap        = mstatus_val;
    w_mstatus_trap[7]     = mstatus_val[3];
    w_mstatus_trap[3]     = 1'b0;
    w_mstatus_trap[12:11] = 2'b11;
  end

  // Trap return: MIE <= MPIE, MPIE <= 1, MPP stays M (machine-only core).
  always_comb begin
    w_mstatus_ret        = mstatus_val;
    w_mstatus_ret[3]     = mstatus_val[7];
    w_mstatus_ret[7]     = 1'b1;
    w_mstatus_ret[12:11] = 2'b11;
  end

  // ---------------------------------------------------------------------------
  // Write ports: decoded from the state register. Reset masks them so a reset
  // landing in a write cycle cancels that write; earlier writes are kept.
  // ---------------------------------------------------------------------------
  always_comb begin
    mepc_wen     = 1'b0;
    mstatus_wen  = 1'b0;
    mcause_wen   = 1'b0;
    mtvec_wen    = 1'b0;
    mepc_data    = '0;
    mstatus_data = '0;
    mcause_data  = '0;
    mtvec_data   = '0;
    if (!rst) begin
      case (r_state)
        T_SAVE: begin
          mepc_wen    = 1'b1;
          mepc_data   = r_pc;
          mcause_wen  = 1'b1;
          mcause_data = r_irq ? IRQ_CAUSE : ECALL_CAUSE;
        end
        T_STAT: begin
          mstatus_wen  = 1'b1;
          mstatus_data = w_mstatus_trap;
        end
        R_STAT: begin
          mstatus_wen  = 1'b1;
          mstatus_data = w_mstatus_ret;
        end
        C_WB: begin
          if (w_csr_wr) begin
            case (r_addr)
              A_MSTATUS: begin mstatus_wen = 1'b1; mstatus_data = w_new; end
              A_MTVEC:   begin mtvec_wen   = 1'b1; mtvec_data   = w_new; end
              A_MEPC:    begin mepc_wen    = 1'b1; mepc_data    = w_new; end
              A_MCAUSE:  begin mcause_wen  = 1'b1; mcause_data  = w_new; end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign csr_num  = {{(XLEN-12){1'b0}}, r_addr};
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign redirect = (r_state == DONE) && r_redirect;
  assign next_pc  = r_next_pc;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_csr_trap_ctrl
//
// Directed bench for csr_trap_ctrl: reset/idle behaviour, ecall, mret,
// Zicsr RW/RS/RC with known and unknown addresses, src_zero suppression and
// reset in the middle of a trap sequence. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_csr_trap_ctrl;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            start;
  logic            is_ecall;
  logic            is_mret;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] rs1_data;
  logic            src_zero;
  logic [XLEN-1:0] pc;
  logic            irq;
  logic [XLEN-1:0] mepc_val;
  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] mtvec_val;
  logic [XLEN-1:0] csr_rst;
  logic [XLEN-1:0] csr_num;
  logic [XLEN-1:0] mepc_data;
  logic [XLEN-1:0] mstatus_data;
  logic [XLEN-1:0] mcause_data;
  logic [XLEN-1:0] mtvec_data;
  logic            mepc_wen;
  logic            mstatus_wen;
  logic            mcause_wen;
  logic            mtvec_wen;
  logic            busy;
  logic            done;
  logic            redirect;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] rd_data;

  int n_chk = 0;
  int n_err = 0;

  csr_trap_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .is_ecall(is_ecall),
    .is_mret(is_mret), .csr_op(csr_op), .csr_addr(csr_addr),
    .rs1_data(rs1_data), .src_zero(src_zero), .pc(pc), .irq(irq),
    .mepc_val(mepc_val), .mstatus_val(mstatus_val), .mtvec_val(mtvec_val),
    .csr_rst(csr_rst), .csr_num(csr_num), .mepc_data(mepc_data),
    .mstatus_data(mstatus_data), .mcause_data(mcause_data),
    .mtvec_data(mtvec_data), .mepc_wen(mepc_wen), .mstatus_wen(mstatus_wen),
    .mcause_wen(mcause_wen), .mtvec_wen(mtvec_wen), .busy(busy),
    .done(done), .redirect(redirect), .next_pc(next_pc), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mepc, mstatus, mcause, mtvec}
  logic [3:0] wens;
  assign wens = {mepc_wen, mstatus_wen, mcause_wen, mtvec_wen};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_req(input logic [1:0] op, input logic [11:0] addr,
                         input logic [63:0] rs1, input logic sz,
                         input logic [63:0] rpc);
    start = 1'b1; is_ecall = 1'b0; is_mret = 1'b0;
    csr_op = op; csr_addr = addr; rs1_data = rs1; src_zero = sz; pc = rpc;
  endtask

  task automatic idle_req();
    start = 1'b0; is_ecall = 1'b0; is_mret = 1'b0; csr_op = 2'b00;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_ecall = 1'b0; is_mret = 1'b0;
    csr_op = 2'b00; csr_addr = 12'h000; rs1_data = '0; src_zero = 1'b0;
    pc = '0; irq = 1'b0; mepc_val = '0; mstatus_val = '0; mtvec_val = '0;
    csr_rst = '0;
    step(); step();

    // Reset state
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_redirect", {63'd0, redirect}, 64'd0);
    chk("rst_wens", {60'd0, wens}, 64'd0);
    chk("rst_next_pc", next_pc, 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_csr_num", csr_num, 64'd0);
    chk("rst_wdata", mepc_data | mstatus_data | mcause_data | mtvec_data, 64'd0);

    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_busy", {63'd0, busy}, 64'd0);
      chk("idle_wens", {60'd0, wens}, 64'd0);
    end

    // start with no op set is ignored
    start = 1'b1;
    step();
    chk("noop_busy", {63'd0, busy}, 64'd0);
    start = 1'b0;

    // ecall
    pc = 64'h8000_0100; mtvec_val = 64'h8000_0401; mstatus_val = 64'ha_0000_1808;
    start = 1'b1; is_ecall = 1'b1; is_mret = 1'b1; csr_op = 2'b01;  // ecall wins
    step();
    chk("ec1_busy", {63'd0, busy}, 64'd1);
    chk("ec1_wens", {60'd0, wens}, 64'b1010);
    chk("ec1_mepc", mepc_data, 64'h8000_0100);
    chk("ec1_mcause", mcause_data, 64'd11);
    step();
    chk("ec2_wens", {60'd0, wens}, 64'b0100);
    chk("ec2_mstatus", mstatus_data, 64'ha_0000_1880);
    chk("ec2_done", {63'd0, done}, 64'd0);
    step();
    chk("ec3_done", {63'd0, done}, 64'd1);
    chk("ec3_redirect", {63'd0, redirect}, 64'd1);
    chk("ec3_next_pc", next_pc, 64'h8000_0400);
    chk("ec3_wens", {60'd0, wens}, 64'd0);
    idle_req();
    step();
    chk("ec4_done", {63'd0, done}, 64'd0);
    chk("ec4_busy", {63'd0, busy}, 64'd0);
    chk("ec4_hold_pc", next_pc, 64'h8000_0400);

    // mret
    mstatus_val = 64'ha_0000_1880; mepc_val = 64'h8000_0104;
    start = 1'b1; is_mret = 1'b1;
    step();
    chk("mr1_wens", {60'd0, wens}, 64'b0100);
    chk("mr1_mstatus", mstatus_data, 64'ha_0000_1888);
    step();
    chk("mr2_done", {63'd0, done}, 64'd1);
    chk("mr2_redirect", {63'd0, redirect}, 64'd1);
    chk("mr2_next_pc", next_pc, 64'h8000_0104);
    idle_req();
    step();

    // CSRRW mtvec, old value 0
    csr_req(2'b01, 12'h305, 64'h8000_0400, 1'b0, 64'h8000_0200);
    csr_rst = 64'd0;
    step();
    chk("rw1_csr_num", csr_num, 64'h305);
    chk("rw1_wens", {60'd0, wens}, 64'b0001);
    chk("rw1_mtvec", mtvec_data, 64'h8000_0400);
    step();
    chk("rw2_done", {63'd0, done}, 64'd1);
    chk("rw2_redirect", {63'd0, redirect}, 64'd0);
    chk("rw2_rd_data", rd_data, 64'd0);
    chk("rw2_next_pc", next_pc, 64'h8000_0204);
    idle_req();
    step();

    // CSRRS mstatus with src_zero: read only
    csr_req(2'b10, 12'h300, 64'hff, 1'b1, 64'h8000_0300);
    csr_rst = 64'ha_0000_1888;
    step();
    chk("rsz_wens", {60'd0, wens}, 64'd0);
    step();
    chk("rsz_rd_data", rd_data, 64'ha_0000_1888);
    chk("rsz_next_pc", next_pc, 64'h8000_0304);
    idle_req();
    step();

    // CSRRC to unknown address: no write, reads 0
    csr_req(2'b11, 12'h7C0, 64'hff, 1'b0, 64'h8000_0400);
    csr_rst = 64'hdead_beef;
    step();
    chk("rcu_wens", {60'd0, wens}, 64'd0);
    step();
    chk("rcu_rd_data", rd_data, 64'd0);
    chk("rcu_done", {63'd0, done}, 64'd1);
    idle_req();
    step();

    // CSRRS mepc: old | rs1
    csr_req(2'b10, 12'h341, 64'h3, 1'b0, 64'h8000_0500);
    csr_rst = 64'h100;
    step();
    chk("rs_wens", {60'd0, wens}, 64'b1000);
    chk("rs_mepc", mepc_data, 64'h103);
    step();
    chk("rs_rd_data", rd_data, 64'h100);
    idle_req();
    step();

    // CSRRC mcause: old & ~rs1
    csr_req(2'b11, 12'h342, 64'hf, 1'b0, 64'h8000_0600);
    csr_rst = 64'hff;
    step();
    chk("rc_wens", {60'd0, wens}, 64'b0010);
    chk("rc_mcause", mcause_data, 64'hf0);
    step();
    chk("rc_rd_data", rd_data, 64'hff);
    idle_req();
    step();

    // Reset in T_STAT: the status write is cancelled, back to IDLE
    mstatus_val = 64'ha_0000_1808; pc = 64'h8000_0700;
    start = 1'b1; is_ecall = 1'b1;
    step();
    chk("rt1_wens", {60'd0, wens}, 64'b1010);
    step();
    rst = 1'b1;
    #1;
    chk("rt2_wens", {60'd0, wens}, 64'd0);
    idle_req();
    step();
    rst = 1'b0;
    chk("rt3_busy", {63'd0, busy}, 64'd0);
    step();
    chk("rt4_busy", {63'd0, busy}, 64'd0);
    chk("rt4_wens", {60'd0, wens}, 64'd0);

    // Interrupt with MIE=1
    mstatus_val = 64'h8; pc = 64'h8000_0800;
    irq = 1'b1; start = 1'b1; csr_op = 2'b01; csr_addr = 12'h305;
    step();
`ifdef CSR_CTRL_IRQ_EN
    chk("irq_wens", {60'd0, wens}, 64'b1010);
    chk("irq_mcause", mcause_data, 64'h8000_0000_0000_0007);
    chk("irq_mepc", mepc_data, 64'h8000_0800);
    irq = 1'b0; idle_req();
    step(); step();
    chk("irq_done", {63'd0, done}, 64'd1);
`else
    // irq is ignored; the CSR op is accepted instead
    chk("noirq_wens", {60'd0, wens}, 64'b0001);
    irq = 1'b0; idle_req();
    step();
    chk("noirq_done", {63'd0, done}, 64'd1);
`endif
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
